// File: rtl/dram_backing_store_if.sv
// Request/response bundle between a requester (master) and the DRAM backing store (slave).
interface dram_backing_store_if;
    logic         dram_valid;
    logic         dram_write;
    logic [31:0]  dram_addr;
    logic [127:0] dram_wdata;
    logic [127:0] dram_rdata;
    logic         dram_ready;
    logic         busy;
    logic         err_overflow;
    logic         err_overrun;

    modport master (
        output dram_valid, dram_write, dram_addr, dram_wdata,
        input  dram_rdata, dram_ready, busy, err_overflow, err_overrun
    );

    modport slave (
        input  dram_valid, dram_write, dram_addr, dram_wdata,
        output dram_rdata, dram_ready, busy, err_overflow, err_overrun
    );
endinterface

// File: rtl/dram_backing_store.sv
// Behavioural DRAM model: fixed-latency single-outstanding reads, posted writes
// through a FIFO that drains into a 128-bit block array, with read forwarding.
module dram_backing_store #(
    parameter int READ_LAT   = 4,
    parameter int WRITE_LAT  = 2,
    parameter int WQ_DEPTH   = 4,
    parameter int MEM_BLOCKS = 1024
) (
    input logic clk,
    input logic reset,
    dram_backing_store_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_BLOCKS);
    localparam int PTR_W = $clog2(WQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [3:0]         rd_cnt_q, rd_cnt_d;
    logic [IDX_W-1:0]   rd_idx_q, rd_idx_d;
    logic [127:0]       rdata_q, rdata_d;
    logic               ovf_q, ovf_d;
    logic               ovr_q, ovr_d;

    logic [IDX_W-1:0]   wq_idx_q  [WQ_DEPTH];
    logic [IDX_W-1:0]   wq_idx_d  [WQ_DEPTH];
    logic [127:0]       wq_data_q [WQ_DEPTH];
    logic [127:0]       wq_data_d [WQ_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   wq_cnt_q, wq_cnt_d;
    logic [3:0]         wl_cnt_q, wl_cnt_d;

    // Contents survive reset on purpose; only the declaration zeroes them.
    logic [127:0]       mem [MEM_BLOCKS] = '{default: '0};

    logic [IDX_W-1:0]   req_idx;
    logic               req_read, req_write;
    logic               retire, push;
    logic               fwd_hit;
    logic [127:0]       fwd_data;
    logic               unused_addr;

    assign req_idx     = bus.dram_addr[IDX_W+3:4];
    assign req_read    = bus.dram_valid & ~bus.dram_write;
    assign req_write   = bus.dram_valid & bus.dram_write;
    assign unused_addr = ^{bus.dram_addr[31:IDX_W+4], bus.dram_addr[3:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            rd_cnt_q <= '0;
            rd_idx_q <= '0;
            rdata_q  <= '0;
            ovf_q    <= 1'b0;
            ovr_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wq_cnt_q <= '0;
            wl_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            rd_idx_q <= rd_idx_d;
            rdata_q  <= rdata_d;
            ovf_q    <= ovf_d;
            ovr_q    <= ovr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wq_cnt_q <= wq_cnt_d;
            wl_cnt_q <= wl_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        wq_idx_q  <= wq_idx_d;
        wq_data_q <= wq_data_d;
        if (retire && !reset)
            mem[wq_idx_q[rd_ptr_q]] <= wq_data_q[rd_ptr_q];
    end

    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        rd_idx_d = rd_idx_q;
        ovr_d    = ovr_q | (req_read & (state_q != IDLE));
        case (state_q)
            IDLE: if (req_read) begin
                rd_idx_d = req_idx;
                rd_cnt_d = 4'(READ_LAT - 2);
                state_d  = WAIT;
            end
            WAIT: if (rd_cnt_q == '0) state_d = RESP;
                  else                rd_cnt_d = rd_cnt_q - 4'd1;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A full queue still accepts a write when the head retires on the same edge.
    always_comb begin
        wq_idx_d  = wq_idx_q;
        wq_data_d = wq_data_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        retire    = (wq_cnt_q != '0) && (wl_cnt_q == 4'(WRITE_LAT - 1));
        push      = req_write && ((wq_cnt_q != CNT_W'(WQ_DEPTH)) || retire);
        ovf_d     = ovf_q | (req_write & ~push);
        if (push) begin
            wq_idx_d[wr_ptr_q]  = req_idx;
            wq_data_d[wr_ptr_q] = bus.dram_wdata;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end
        if (retire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            wl_cnt_d = '0;
        end else if (wq_cnt_q != '0) begin
            wl_cnt_d = wl_cnt_q + 4'd1;
        end else begin
            wl_cnt_d = '0;
        end
        wq_cnt_d = wq_cnt_q + CNT_W'(push) - CNT_W'(retire);
    end

    // Scan oldest to newest so the youngest matching entry wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            if ((CNT_W'(i) < wq_cnt_q) &&
                (wq_idx_q[PTR_W'(rd_ptr_q + PTR_W'(i))] == rd_idx_q)) begin
                fwd_hit  = 1'b1;
                fwd_data = wq_data_q[PTR_W'(rd_ptr_q + PTR_W'(i))];
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (state_q == WAIT && rd_cnt_q == '0)
            rdata_d = fwd_hit ? fwd_data : mem[rd_idx_q];
        bus.dram_rdata   = rdata_q;
        bus.dram_ready   = (state_q == RESP);
        bus.busy         = (state_q != IDLE) || (wq_cnt_q != '0);
        bus.err_overflow = ovf_q;
        bus.err_overrun  = ovr_q;
    end
endmodule

// File: tb/tb_dram_backing_store.sv
// Directed self-checking bench for dram_backing_store at default parameters.
module tb_dram_backing_store;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dram_backing_store_if bus ();

    dram_backing_store #(
        .READ_LAT(4), .WRITE_LAT(2), .WQ_DEPTH(4), .MEM_BLOCKS(1024)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Each call is one clock cycle: drive after the edge, return mid-cycle.
    task automatic applyStimulus(input logic rst, input logic v, input logic w,
                                 input logic [31:0] a, input logic [127:0] d);
        @(posedge clk);
        #1;
        reset          = rst;
        bus.dram_valid = v;
        bus.dram_write = w;
        bus.dram_addr  = a;
        bus.dram_wdata = d;
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 128'h0);
    endtask

    task automatic writeReq(input logic [31:0] a, input logic [127:0] d);
        applyStimulus(1'b0, 1'b1, 1'b1, a, d);
    endtask

    task automatic expectRead(input string tag, input logic [31:0] a,
                              input logic [127:0] expected);
        applyStimulus(1'b0, 1'b1, 1'b0, a, 128'h0);
        for (int k = 1; k <= 6; k++) begin
            idle();
            checkOutput({tag, "_ready"}, 128'(bus.dram_ready), 128'(k == 4));
            if (k == 4) checkOutput({tag, "_rdata"}, bus.dram_rdata, expected);
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.dram_valid = 1'b0;
        bus.dram_write = 1'b0;
        bus.dram_addr  = 32'h0;
        bus.dram_wdata = 128'h0;
        repeat (3) @(posedge clk);
        idle();
        checkOutput("rst_ready", 128'(bus.dram_ready), 128'd0);
        checkOutput("rst_rdata", bus.dram_rdata, 128'd0);
        checkOutput("rst_busy", 128'(bus.busy), 128'd0);
        checkOutput("rst_ovf", 128'(bus.err_overflow), 128'd0);
        checkOutput("rst_ovr", 128'(bus.err_overrun), 128'd0);

        // Read of a never-written block: pulse only in cycle 4.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0040, 128'h0);
        checkOutput("lat_ready_c0", 128'(bus.dram_ready), 128'd0);
        for (int k = 1; k <= 5; k++) begin
            idle();
            checkOutput("lat_ready", 128'(bus.dram_ready), 128'(k == 4));
            checkOutput("lat_busy", 128'(bus.busy), 128'(k <= 4));
            if (k == 4) checkOutput("lat_rdata", bus.dram_rdata, 128'd0);
        end

        writeReq(32'h0000_1230, 128'hDEAD_BEEF);
        expectRead("rd_after_wr", 32'h0000_1230, 128'hDEAD_BEEF);
        repeat (10) idle();
        checkOutput("drained_busy", 128'(bus.busy), 128'd0);
        expectRead("rd_array", 32'h0000_1230, 128'hDEAD_BEEF);

        // Four fillers back up the queue so all three 0x10 writes are still
        // queued when the read samples; the alias write is the newest match.
        writeReq(32'h0000_2000, 128'h11);
        writeReq(32'h0000_2010, 128'h12);
        writeReq(32'h0000_2020, 128'h13);
        writeReq(32'h0000_2030, 128'h14);
        writeReq(32'h0000_0010, 128'h1);
        writeReq(32'h0000_0010, 128'h2);
        writeReq(32'h0001_0010, 128'h3);
        expectRead("fwd_newest", 32'h0000_0010, 128'h3);
        checkOutput("full_retire_ovf", 128'(bus.err_overflow), 128'd0);
        repeat (20) idle();
        expectRead("alias_last_wins", 32'h0000_0010, 128'h3);
        expectRead("alias_upper", 32'h0001_0010, 128'h3);
        expectRead("filler", 32'h0000_2020, 128'h13);

        // Back-to-back writes: the one in cycle 7 meets a full queue with no
        // retire and is dropped; cycle 8 coincides with a retire and is kept.
        for (int i = 0; i <= 8; i++) begin
            writeReq(32'h0000_3000 + 32'(i * 16), 128'(32'h100 + 32'(i)));
            if (i == 7) checkOutput("ovf_before", 128'(bus.err_overflow), 128'd0);
            if (i == 8) checkOutput("ovf_set", 128'(bus.err_overflow), 128'd1);
        end
        repeat (25) idle();
        checkOutput("ovf_sticky", 128'(bus.err_overflow), 128'd1);
        expectRead("dropped", 32'h0000_3070, 128'h0);
        expectRead("kept_after_full", 32'h0000_3080, 128'h108);
        expectRead("before_full", 32'h0000_3060, 128'h106);

        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_3000, 128'h0);
        idle();
        checkOutput("ovr_before", 128'(bus.err_overrun), 128'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_3010, 128'h0);
        checkOutput("ovr_c2_ready", 128'(bus.dram_ready), 128'd0);
        for (int k = 3; k <= 8; k++) begin
            idle();
            checkOutput("ovr_ready", 128'(bus.dram_ready), 128'(k == 4));
            if (k == 3) checkOutput("ovr_set", 128'(bus.err_overrun), 128'd1);
            if (k == 4) checkOutput("ovr_rdata", bus.dram_rdata, 128'h100);
        end

        // Reset in cycle 2 aborts the read and drops the still-queued write.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_3020, 128'h0);
        writeReq(32'h0000_3010, 128'h55);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 128'h0);
        for (int k = 3; k <= 10; k++) begin
            idle();
            checkOutput("abort_ready", 128'(bus.dram_ready), 128'd0);
            if (k == 3) begin
                checkOutput("abort_rdata", bus.dram_rdata, 128'd0);
                checkOutput("abort_busy", 128'(bus.busy), 128'd0);
                checkOutput("abort_ovf", 128'(bus.err_overflow), 128'd0);
                checkOutput("abort_ovr", 128'(bus.err_overrun), 128'd0);
            end
        end
        expectRead("discarded_wr", 32'h0000_3010, 128'h101);
        expectRead("persist", 32'h0000_3020, 128'h102);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
